pwm_peripheral: RTL and testbench



---
 rtl/pwm_pkg.sv | 29 ++
 rtl/pwm_peripheral_if.sv | 22 ++
 rtl/pwm_timebase.sv | 41 ++++
 rtl/pwm_peripheral.sv | 66 ++++++
 tb/tb_pwm_peripheral.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/pwm_pkg.sv
// Shared constants for the PWM peripheral and the SPI register block that feeds it.
// Also holds the per-channel mode decode, so every user of the package decodes modes the same way.
package pwm_pkg;

  localparam logic [7:0] ADDR_EN_OUT_LO = 8'h00;
  localparam logic [7:0] ADDR_EN_OUT_HI = 8'h01;
  localparam logic [7:0] ADDR_EN_PWM_LO = 8'h02;
  localparam logic [7:0] ADDR_EN_PWM_HI = 8'h03;
  localparam logic [7:0] ADDR_DUTY      = 8'h04;
  localparam logic [7:0] MAX_ADDRESS    = 8'h04;

  localparam int         PWM_PRESCALE_DEFAULT = 13;
  localparam int         PWM_CNT_W_DEFAULT    = 8;
  localparam logic [7:0] DUTY_FULL            = 8'hFF;

  typedef enum logic [1:0] {
    CH_OFF  = 2'd0,
    CH_HIGH = 2'd1,
    CH_PWM  = 2'd2
  } ch_mode_e;

  // The output enable dominates: a disabled pin is low whatever its PWM select says.
  function automatic ch_mode_e ch_mode(input logic en_out, input logic en_pwm);
    if (!en_out) return CH_OFF;
    if (!en_pwm) return CH_HIGH;
    return CH_PWM;
  endfunction

endpackage

// File: rtl/pwm_peripheral_if.sv
// Register-side bundle: the five control registers in, the pin drive and the period strobe out.
interface pwm_peripheral_if;

  logic [7:0]  en_reg_out_7_0;
  logic [7:0]  en_reg_out_15_8;
  logic [7:0]  en_reg_pwm_7_0;
  logic [7:0]  en_reg_pwm_15_8;
  logic [7:0]  pwm_duty_cycle;
  logic [15:0] out;
  logic        period_start;

  modport master (
    output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
    input  out, period_start
  );

  modport slave (
    input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
    output out, period_start
  );

endinterface

// File: rtl/pwm_timebase.sv
// Free-running PWM timebase: a prescaler feeds a wrapping period counter.
// boundary_o is high on the last clk of each period.
module pwm_timebase #(
  parameter int PRESCALE = 13,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] cnt_o,
  output logic             boundary_o
);

  localparam int               PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0]  prescale_q, prescale_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step;

  // NOTE: every variable driven here gets a value before any branch, so no latch can be inferred.
  always_comb begin
    step       = (prescale_q == PS_LAST);
    prescale_d = step ? '0 : prescale_q + PS_W'(1);
    cnt_d      = step ? cnt_q + CNT_W'(1) : cnt_q;
    boundary_o = step && (cnt_q == '1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale_q <= '0;
      cnt_q      <= '0;
    end else begin
      prescale_q <= prescale_d;
      cnt_q      <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pwm_peripheral.sv
// 16-pin output stage: each pin is off, forced high, or follows one shared PWM waveform.
// Duty is shadowed at period boundaries so no pin ever emits a truncated or extra pulse.
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int PRESCALE = PWM_PRESCALE_DEFAULT,
  parameter int CNT_W    = PWM_CNT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  pwm_peripheral_if.slave   bus
);

  logic [CNT_W-1:0] cnt;
  logic             boundary;

  logic [CNT_W-1:0] duty_shadow_q, duty_shadow_d;
  logic [15:0]      out_q, out_d;
  logic             period_start_q;
  logic [15:0]      en_out, en_pwm;
  logic             pwm;

  pwm_timebase #(
    .PRESCALE (PRESCALE),
    .CNT_W    (CNT_W)
  ) u_timebase (
    .clk        (clk),
    .rst_n      (rst_n),
    .cnt_o      (cnt),
    .boundary_o (boundary)
  );

  assign en_out = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
  assign en_pwm = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};

  // All-ones duty means 100% high rather than 255/256, hence the explicit full-scale term.
  always_comb begin
    duty_shadow_d = boundary ? bus.pwm_duty_cycle : duty_shadow_q;
    pwm           = (duty_shadow_q == '1) || (cnt < duty_shadow_q);
    out_d         = '0;
    for (int i = 0; i < 16; i++) begin
      case (ch_mode(en_out[i], en_pwm[i]))
        CH_HIGH: out_d[i] = 1'b1;
        CH_PWM:  out_d[i] = pwm;
        default: out_d[i] = 1'b0;
      endcase
    end
  end

  // NOTE: every flop here is reset; a plain register set like this has no memory to leave unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_shadow_q  <= '0;
      out_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      duty_shadow_q  <= duty_shadow_d;
      out_q          <= out_d;
      period_start_q <= boundary;
    end
  end

  assign bus.out          = out_q;
  assign bus.period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Scoreboard bench for pwm_peripheral: stimulus pushes one expectation per PWM period,
// a monitor measures each period between period_start pulses and compares.
module tb_pwm_peripheral;

  localparam int PERIOD_CLK = 3328;
  localparam int WAIT_LIMIT = 4000;

  typedef struct packed {
    logic [15:0] en_out;
    logic [15:0] en_pwm;
    logic [12:0] hi_pwm;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t exp_q[$];

  pwm_peripheral_if bus();

  pwm_peripheral dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  task automatic set_regs(input logic [15:0] en_out, input logic [15:0] en_pwm);
    bus.en_reg_out_7_0  = en_out[7:0];
    bus.en_reg_out_15_8 = en_out[15:8];
    bus.en_reg_pwm_7_0  = en_pwm[7:0];
    bus.en_reg_pwm_15_8 = en_pwm[15:8];
  endtask

  // Waits (bounded) for the negedge at which period_start is visible.
  task automatic wait_ps(output int n, output logic [15:0] seen);
    n    = 0;
    seen = '0;
    do begin
      @(negedge clk);
      n++;
      seen |= bus.out;
    end while (!bus.period_start && n < WAIT_LIMIT);
    check("period_start_seen", 32'(bus.period_start), 32'd1);
  endtask

  task automatic push_exp(input logic [15:0] en_out, input logic [15:0] en_pwm, input int hi);
    exp_t e;
    e.en_out = en_out;
    e.en_pwm = en_pwm;
    e.hi_pwm = 13'(hi);
    exp_q.push_back(e);
  endtask

  // Monitor: a window runs from the clk after one period_start to the clk of the next.
  initial begin
    int          hi_cnt[16];
    int          len;
    int          exp_hi;
    logic [15:0] first, prev, rose, exp_first;
    bit          started;
    exp_t        e;
    started = 0;
    len     = 0;
    first   = '0;
    prev    = '0;
    rose    = '0;
    foreach (hi_cnt[i]) hi_cnt[i] = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        started = 0;
        continue;
      end
      if (started) begin
        if (len == 0) first = bus.out;
        else          rose |= bus.out & ~prev;
        for (int i = 0; i < 16; i++) hi_cnt[i] += int'(bus.out[i]);
        len++;
        prev = bus.out;
      end
      if (bus.period_start) begin
        if (started && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("period_len", len, PERIOD_CLK);
          for (int i = 0; i < 16; i++) begin
            exp_hi       = !e.en_out[i] ? 0 : (!e.en_pwm[i] ? PERIOD_CLK : int'(e.hi_pwm));
            exp_first[i] = e.en_out[i] & (~e.en_pwm[i] | (e.hi_pwm != 0));
            check($sformatf("high_clk_pin%0d", i), hi_cnt[i], exp_hi);
          end
          check("first_sample", 32'(first), 32'(exp_first));
          check("no_late_rise", 32'(rose), 32'd0);
        end
        started = 1;
        len     = 0;
        rose    = '0;
        foreach (hi_cnt[i]) hi_cnt[i] = 0;
      end
    end
  end

  initial begin
    int          n;
    logic [15:0] seen;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    set_regs(16'h0000, 16'h0000);
    bus.pwm_duty_cycle = 8'h00;

    repeat (3) @(negedge clk);
    check("reset_out", 32'(bus.out), 32'h0);
    check("reset_period_start", 32'(bus.period_start), 32'd0);
    rst_n = 1'b1;

    // First pulse 3328 clk after release, out idle throughout.
    wait_ps(n, seen);
    check("first_pulse_delay", n, PERIOD_CLK);
    check("idle_out_first_period", 32'(seen), 32'h0);
    push_exp(16'h0000, 16'h0000, 0);
    wait_ps(n, seen);
    push_exp(16'h0000, 16'h0000, 0);
    wait_ps(n, seen);

    // Enable register change visible one clk later; this window is left unchecked.
    repeat (100) @(negedge clk);
    set_regs(16'h00FF, 16'h0000);
    check("enable_not_early", 32'(bus.out), 32'h0);
    @(negedge clk);
    check("enable_latency", 32'(bus.out), 32'h00FF);
    bus.pwm_duty_cycle = 8'h80;
    wait_ps(n, seen);

    // Duty 0x80 on all channels; queue duty 0x00 for the next period.
    set_regs(16'hFFFF, 16'hFFFF);
    push_exp(16'hFFFF, 16'hFFFF, 1664);
    bus.pwm_duty_cycle = 8'h00;
    wait_ps(n, seen);

    // Duty 0x00 with mixed modes: pin 15 disabled, pins 7..4 forced high.
    set_regs(16'h7FFF, 16'hFF0F);
    push_exp(16'h7FFF, 16'hFF0F, 0);
    bus.pwm_duty_cycle = 8'hFF;
    wait_ps(n, seen);

    // Duty 0xFF is fully high.
    set_regs(16'hFFFF, 16'hFFFF);
    push_exp(16'hFFFF, 16'hFFFF, PERIOD_CLK);
    bus.pwm_duty_cycle = 8'h40;
    wait_ps(n, seen);

    // Duty 0x40, rewritten to 0xC0 mid-period: current period unaffected.
    push_exp(16'hFFFF, 16'hFFFF, 832);
    repeat (1600) @(negedge clk);
    bus.pwm_duty_cycle = 8'hC0;
    wait_ps(n, seen);
    push_exp(16'hFFFF, 16'hFFFF, 2496);
    wait_ps(n, seen);

    // Asynchronous reset mid-period while pins are high.
    repeat (200) @(negedge clk);
    check("pre_reset_out", 32'(bus.out), 32'hFFFF);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_out", 32'(bus.out), 32'h0);
    check("async_reset_period_start", 32'(bus.period_start), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Shadow restarts at 0: PWM pins low for the first period, then duty 0xC0 applies.
    wait_ps(n, seen);
    check("post_reset_pulse_delay", n, PERIOD_CLK);
    check("post_reset_first_period_low", 32'(seen), 32'h0);
    push_exp(16'hFFFF, 16'hFFFF, 2496);
    wait_ps(n, seen);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
